io_conditioner: RTL and testbench
=================================

Name: io_conditioner

Overview:
- Parametrised, multi-channel conditioner for the board's push-button and switch inputs (run_i, continue_i, sw_i style signals) before they reach processor_top control logic.
- Per channel it performs:
  - metastability synchronisation
  - counter-based debounce
  - registered single-cycle rise and fall pulses
  - optional hold-to-auto-repeat press pulses
- Replaces ad-hoc per-signal sync/debounce logic with one block instantiated at the top level.

Parameters:
- N_CH, 2: number of independent input channels (>=1).
- SYNC_STAGES, 2: flip-flops in each synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 16: consecutive clocks a changed input must hold before the level is accepted (>=1).
- REPEAT_EN, 0: 1 enables auto-repeat on press_o; 0 makes press_o equal rise_o.
- REPEAT_DELAY, 8: clocks from the rise pulse to the first repeat pulse (>=1).
- REPEAT_PERIOD, 3: clocks between subsequent repeat pulses (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately and releases synchronously to clk.
- raw_i  input  N_CH  asynchronous raw inputs, one bit per channel.
- level_o  output  N_CH  debounced, synchronised level.
- rise_o  output  N_CH  one-clock pulse when level_o goes 0->1.
- fall_o  output  N_CH  one-clock pulse when level_o goes 1->0.
- press_o  output  N_CH  rise pulse plus auto-repeat pulses while held.

Behaviour:
- Reset (reset=0), cleared asynchronously and held at 0 while reset is low:
  - all sync flops, level_o, rise_o, fall_o, press_o
  - debounce counters and repeat counters
- Synchroniser: raw_i is shifted through SYNC_STAGES flops; s = last stage.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES+1), per channel:
  - s == level: counter <= 0.
  - s != level and counter == DEBOUNCE_CYCLES-1: level <= s, counter <= 0.
  - otherwise: counter increments.
- Latency: a clean raw edge sampled at clock edge k changes level_o at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (S+D-1 edges after sampling).
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES returns the counter to 0; level_o, rise_o and fall_o do not change.
- rise_o / fall_o:
  - registered; asserted in exactly the cycle level_o first shows its new value.
  - high for exactly one clock.
  - never both high in the same cycle.
- press_o with REPEAT_EN=0: identical to rise_o.
- press_o with REPEAT_EN=1:
  - pulses with rise_o.
  - repeat counter clears on rise and counts while level_o=1.
  - further one-clock pulses at REPEAT_DELAY clocks after the rise pulse, then every REPEAT_PERIOD clocks.
  - after the first repeat, the counter wraps at REPEAT_PERIOD; it never overflows.
  - level_o falling clears the repeat counter; no press pulse in the fall cycle or after it.
- Channels are fully independent. Simultaneous transitions on several channels produce pulses in the same cycle on each.
- Reset mid-operation:
  - all pulses abort and counters clear.
  - after release, a channel with raw_i held at 1 produces a normal rise after S+D-1 edges; this is a legitimate press.
- Counter saturation: debounce counters never exceed DEBOUNCE_CYCLES-1.
- No combinational path from raw_i to any output.

Test Plan:
- Config for all scenarios: N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Reset: reset=0 with raw_i=2'b11 -> all outputs 0. Release and hold raw_i=2'b11 -> level_o=2'b11 exactly 5 edges after first sample; rise_o=2'b11 for 1 clock.
- Glitch: ch0 raw pulses high for 3 clocks then low -> level_o[0], rise_o[0] and press_o[0] stay 0 throughout.
- Clean press/release on ch0, held 30 clocks:
  - rise_o[0] one pulse; press_o[0] pulses at rise+0, +8, +11, +14, ...
  - on release, fall_o[0] one pulse 5 edges after raw falls; no press_o after fall.
- Bouncing edge: ch1 raw toggles 1,0,1,0,1 on consecutive clocks, then stays 1 -> exactly one rise_o[1] pulse, 5 edges after the final toggle sampled.
- Simultaneous channels: both raw bits rise on the same clock -> rise_o=2'b11 in the same cycle. ch1 independently released later -> fall_o=2'b10 only.
- Mid-operation reset: assert reset during ch0 debounce count (counter=2) and during repeat hold -> outputs 0 immediately. After release with raw held 1, a fresh rise comes 5 edges after the first sampling edge.

Source files
------------

// File: rtl/io_conditioner.sv
// Multi-channel input conditioner: synchroniser, counter debounce, registered
// rise/fall pulses and optional hold-to-repeat press pulses per channel.
module io_conditioner #(
    parameter int unsigned N_CH            = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] press_o
);

    localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  sync_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DbW-1:0] db_cnt_q, db_cnt_d;
        logic           level_q, level_d;
        logic           rise_q, rise_d;
        logic           fall_q, fall_d;
        logic           update;

        // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
        always_comb begin
            update   = (sync_s[c] != level_q) && (db_cnt_q == DbLast);
            level_d  = update ? sync_s[c] : level_q;
            rise_d   = update && sync_s[c];
            fall_d   = update && !sync_s[c];
            db_cnt_d = db_cnt_q + DbW'(1);
            if ((sync_s[c] == level_q) || update) begin
                db_cnt_d = '0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
            end
        end

        assign level_o[c] = level_q;
        assign rise_o[c]  = rise_q;
        assign fall_o[c]  = fall_q;

        if (REPEAT_EN != 0) begin : g_repeat
            localparam int unsigned RpMax = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                            REPEAT_DELAY : REPEAT_PERIOD;
            localparam int unsigned RpW   = (RpMax > 1) ? $clog2(RpMax) : 1;

            logic [RpW-1:0] rp_cnt_q, rp_cnt_d;
            logic           rp_arm_q, rp_arm_d;
            logic           press_q, press_d;
            logic           rp_hit;

            // rp_arm marks that the first (delayed) repeat has fired; after that
            // the counter wraps at REPEAT_PERIOD.
            always_comb begin
                rp_cnt_d = '0;
                rp_arm_d = 1'b0;
                rp_hit   = 1'b0;
                press_d  = rise_d;
                if (level_q && !fall_d) begin
                    rp_hit   = rp_arm_q ? (rp_cnt_q == RpW'(REPEAT_PERIOD - 1)) :
                                          (rp_cnt_q == RpW'(REPEAT_DELAY - 1));
                    press_d  = rp_hit;
                    rp_arm_d = rp_arm_q | rp_hit;
                    rp_cnt_d = rp_hit ? '0 : rp_cnt_q + RpW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rp_cnt_q <= '0;
                    rp_arm_q <= 1'b0;
                    press_q  <= 1'b0;
                end else begin
                    rp_cnt_q <= rp_cnt_d;
                    rp_arm_q <= rp_arm_d;
                    press_q  <= press_d;
                end
            end

            assign press_o[c] = press_q;
        end else begin : g_no_repeat
            assign press_o[c] = rise_q;
        end
    end

endmodule

// File: tb/tb_io_conditioner.sv
// Self-checking bench for io_conditioner: directed scenarios plus randomized
// stimulus compared every cycle against a history-based reference model.
module tb_io_conditioner;

    localparam int S      = 2;
    localparam int D      = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 3;
    localparam int HL     = S + D;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] raw   = 2'b00;
    logic [1:0] level_o, rise_o, fall_o, press_o;

    int total = 0;
    int bad   = 0;

    io_conditioner #(
        .N_CH           (2),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .press_o(press_o)
    );

    initial forever #5 clk = ~clk;

    // Reference: a level flips once the last D synchronised samples (raw seen
    // S edges earlier) all disagree with it; press follows hold time arithmetic.
    typedef struct packed {
        logic [HL-1:0][1:0] hist;
        logic [1:0]         level;
        logic [1:0]         rise;
        logic [1:0]         fall;
        logic [1:0]         press;
        logic [1:0][31:0]   held;
    } model_t;

    model_t ms = '0;

    function automatic model_t model_step(model_t m, logic [1:0] r);
        model_t nx;
        logic   flip;
        int     d;
        nx      = m;
        nx.hist = {m.hist[HL-2:0], r};
        for (int c = 0; c < 2; c++) begin
            flip = 1'b1;
            for (int j = S; j < S + D; j++) begin
                if (nx.hist[j][c] == m.level[c]) flip = 1'b0;
            end
            nx.rise[c]  = flip & ~m.level[c];
            nx.fall[c]  = flip & m.level[c];
            nx.level[c] = m.level[c] ^ flip;
            if (nx.rise[c]) nx.held[c] = 0;
            else if (nx.level[c]) nx.held[c] = m.held[c] + 1;
            else nx.held[c] = 0;
            d = int'(nx.held[c]);
            nx.press[c] = nx.level[c] &&
                          (d == 0 || d == DELAY || (d > DELAY && (d - DELAY) % PERIOD == 0));
        end
        return nx;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) ms <= '0;
        else ms <= model_step(ms, raw);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        raw = 2'b00;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_reset();
        int first_lv;
        int rise_e;
        int n_rise;
        first_lv = 0;
        rise_e   = 0;
        n_rise   = 0;
        reset    = 1'b0;
        raw      = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({level_o, rise_o, fall_o, press_o} !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold got=%b want=0", {level_o, rise_o, fall_o, press_o});
            end
        end
        reset = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            total++;
            if ({level_o, rise_o, fall_o, press_o} !== {ms.level, ms.rise, ms.fall, ms.press}) begin
                bad++;
                $display("FAIL reset_model e=%0d got=%b want=%b", e,
                         {level_o, rise_o, fall_o, press_o}, {ms.level, ms.rise, ms.fall, ms.press});
            end
            if (rise_o !== 2'b00) begin
                n_rise++;
                if (rise_o === 2'b11) rise_e = e;
            end
            if (first_lv == 0 && level_o === 2'b11) first_lv = e;
        end
        total++;
        if (first_lv - 1 != 5) begin
            bad++;
            $display("FAIL reset_latency got=%0d want=5", first_lv - 1);
        end
        total++;
        if (n_rise != 1 || rise_e != first_lv) begin
            bad++;
            $display("FAIL reset_rise got=%0d pulses at edge %0d want=1 at edge %0d",
                     n_rise, rise_e, first_lv);
        end
        settle();
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 13; i++) begin
            raw = (i < 3) ? 2'b01 : 2'b00;
            tick();
            total++;
            if ({level_o[0], rise_o[0], press_o[0]} !== 3'b000 ||
                {level_o, rise_o, fall_o, press_o} !== {ms.level, ms.rise, ms.fall, ms.press}) begin
                bad++;
                $display("FAIL glitch i=%0d got=%b want=%b", i,
                         {level_o, rise_o, fall_o, press_o}, {ms.level, ms.rise, ms.fall, ms.press});
            end
        end
    endtask

    task automatic test_press_release();
        int p[$];
        int exp_p[9] = '{0, 8, 11, 14, 17, 20, 23, 26, 29};
        int rise_j;
        int fall_j;
        int n_rise;
        int n_fall;
        int late;
        rise_j = -1;
        fall_j = -1;
        n_rise = 0;
        n_fall = 0;
        late   = 0;
        raw    = 2'b01;
        for (int j = 0; j < 45; j++) begin
            if (j == 30) raw = 2'b00;
            tick();
            total++;
            if ({level_o, rise_o, fall_o, press_o} !== {ms.level, ms.rise, ms.fall, ms.press}) begin
                bad++;
                $display("FAIL press_model j=%0d got=%b want=%b", j,
                         {level_o, rise_o, fall_o, press_o}, {ms.level, ms.rise, ms.fall, ms.press});
            end
            if (rise_o[0]) begin n_rise++; rise_j = j; end
            if (fall_o[0]) begin n_fall++; fall_j = j; end
            if (press_o[0]) begin
                if (fall_j >= 0) late++;
                else if (rise_j >= 0) p.push_back(j - rise_j);
            end
        end
        total++;
        if (n_rise != 1 || rise_j != 5) begin
            bad++;
            $display("FAIL press_rise got=%0d at %0d want=1 at 5", n_rise, rise_j);
        end
        total++;
        if (p.size() != 9) begin
            bad++;
            $display("FAIL press_count got=%0d want=9", p.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                total++;
                if (p[i] != exp_p[i]) begin
                    bad++;
                    $display("FAIL press_offset i=%0d got=%0d want=%0d", i, p[i], exp_p[i]);
                end
            end
        end
        total++;
        if (n_fall != 1 || fall_j - 30 != 5 || late != 0) begin
            bad++;
            $display("FAIL release got=%0d falls, latency %0d, %0d late presses want=1, 5, 0",
                     n_fall, fall_j - 30, late);
        end
    endtask

    task automatic test_bounce();
        logic vals[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   n_rise;
        int   rise_j;
        n_rise = 0;
        rise_j = -1;
        for (int i = 0; i < 5; i++) begin
            raw[1] = vals[i];
            tick();
            if (rise_o[1]) n_rise++;
        end
        for (int j = 1; j <= 12; j++) begin
            tick();
            total++;
            if ({level_o, rise_o, fall_o, press_o} !== {ms.level, ms.rise, ms.fall, ms.press}) begin
                bad++;
                $display("FAIL bounce_model j=%0d got=%b want=%b", j,
                         {level_o, rise_o, fall_o, press_o}, {ms.level, ms.rise, ms.fall, ms.press});
            end
            if (rise_o[1]) begin n_rise++; rise_j = j; end
        end
        total++;
        if (n_rise != 1 || rise_j != 5) begin
            bad++;
            $display("FAIL bounce_rise got=%0d at %0d want=1 at 5", n_rise, rise_j);
        end
        settle();
    endtask

    task automatic test_simultaneous();
        logic [1:0] first_rise;
        logic [1:0] fall_val;
        int         n_rise;
        int         n_fall;
        first_rise = 2'b00;
        fall_val   = 2'b00;
        n_rise     = 0;
        n_fall     = 0;
        raw        = 2'b11;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (rise_o !== 2'b00) begin
                n_rise++;
                if (first_rise === 2'b00) first_rise = rise_o;
            end
        end
        total++;
        if (n_rise != 1 || first_rise !== 2'b11) begin
            bad++;
            $display("FAIL simul_rise got=%0d cycles first=%b want=1 cycle 11", n_rise, first_rise);
        end
        raw = 2'b01;
        for (int j = 0; j < 10; j++) begin
            tick();
            total++;
            if ({level_o, rise_o, fall_o, press_o} !== {ms.level, ms.rise, ms.fall, ms.press}) begin
                bad++;
                $display("FAIL simul_model j=%0d got=%b want=%b", j,
                         {level_o, rise_o, fall_o, press_o}, {ms.level, ms.rise, ms.fall, ms.press});
            end
            if (fall_o !== 2'b00) begin
                n_fall++;
                fall_val = fall_o;
            end
        end
        total++;
        if (n_fall != 1 || fall_val !== 2'b10) begin
            bad++;
            $display("FAIL simul_fall got=%0d cycles val=%b want=1 cycle 10", n_fall, fall_val);
        end
        settle();
    endtask

    task automatic test_mid_reset();
        int first_lv;
        for (int pass = 0; pass < 2; pass++) begin
            raw = 2'b01;
            // pass 0: abort while debounce counter is at 2; pass 1: abort during repeat hold
            for (int i = 0; i < ((pass == 0) ? 4 : 18); i++) tick();
            if (pass == 1) begin
                total++;
                if (level_o !== 2'b01) begin
                    bad++;
                    $display("FAIL midrst_pre got=%b want=01", level_o);
                end
            end
            reset = 1'b0;
            #1;
            total++;
            if ({level_o, rise_o, fall_o, press_o} !== 8'h00) begin
                bad++;
                $display("FAIL midrst_clear pass=%0d got=%b want=0", pass,
                         {level_o, rise_o, fall_o, press_o});
            end
            tick();
            tick();
            reset    = 1'b1;
            first_lv = 0;
            for (int e = 1; e <= 12; e++) begin
                tick();
                total++;
                if ({level_o, rise_o, fall_o, press_o} !== {ms.level, ms.rise, ms.fall, ms.press}) begin
                    bad++;
                    $display("FAIL midrst_model e=%0d got=%b want=%b", e,
                             {level_o, rise_o, fall_o, press_o}, {ms.level, ms.rise, ms.fall, ms.press});
                end
                if (first_lv == 0 && rise_o[0]) first_lv = e;
            end
            total++;
            if (first_lv - 1 != 5) begin
                bad++;
                $display("FAIL midrst_rise pass=%0d got=%0d want=5", pass, first_lv - 1);
            end
        end
        settle();
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                raw  = 2'($urandom_range(0, 3));
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 25);
            end
            hold--;
            if ($urandom_range(0, 399) == 0) reset = 1'b0;
            tick();
            reset = 1'b1;
            total++;
            if ({level_o, rise_o, fall_o, press_o} !== {ms.level, ms.rise, ms.fall, ms.press}) begin
                bad++;
                $display("FAIL random i=%0d raw=%b got=%b want=%b", i, raw,
                         {level_o, rise_o, fall_o, press_o}, {ms.level, ms.rise, ms.fall, ms.press});
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press_release();
        test_bounce();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
